branch_predict_unit: RTL and testbench
======================================

# branch_predict_unit

Parametrised successor to the combinational branch decision logic. The block resolves branch conditions from ALU flags in EX, and adds a PC-indexed table of 2-bit saturating counters (BHT) that supplies taken/not-taken predictions to fetch. It flags mispredictions for the pipeline flush logic and keeps saturating performance counters. It sits between IF, which looks up predictions, and EX, which resolves branches and trains the table.

## Interface
- `ENTRIES`, 64: number of BHT entries. Must be a power of two, ≥ 2. `IDX_W = $clog2(ENTRIES)`.
- `XLEN`, 32: PC width.
- `STAT_W`, 32: width of the performance counters.
- `clk`  in  1: the single clock.
- `rst`  in  1: reset. Synchronous and active-high.
- `if_pc`  in  XLEN: fetch PC to predict.
- `if_pred_taken`  out  1: prediction for `if_pc`. Combinational.
- `ex_valid`  in  1: EX holds a valid branch or jump.
- `ex_branch`  in  3: condition code. Encodings:
  - 000 eq
  - 001 ne
  - 100 lt
  - 101 ge
  - 110 ltu
  - 111 geu
  - 011 jump
  - 010 never
- `ex_zero`, `ex_carry`, `ex_sign`, `ex_overflow`  in  1 each: ALU flags from the compare.
- `ex_pc`  in  XLEN: PC of the EX instruction.
- `ex_pred_taken`  in  1: prediction that was carried down the pipeline with the instruction.
- `ex_taken`  out  1: resolved outcome. Combinational.
- `ex_mispredict`  out  1: `ex_valid & (ex_taken != ex_pred_taken)`. Combinational.
- `stat_clear`  in  1: synchronous clear of both statistics counters.
- `stat_branches`  out  STAT_W: number of resolved conditional branches.
- `stat_mispredicts`  out  STAT_W: number of mispredicted conditional branches.

## Operation
- **Resolution:**
  - eq: taken = zero.
  - ne: taken = ~zero.
  - lt: taken = sign ^ overflow.
  - ge: taken = ~(sign ^ overflow).
  - ltu: taken = ~carry.
  - geu: taken = carry.
  - jump: taken = 1.
  - never: taken = 0.
- **Conditional branch:** `ex_branch` ∈ {000, 001, 100, 101, 110, 111}.
- **Index:** `pc[IDX_W+1:2]`. Word-aligned; low bits are ignored. Aliasing between PCs that share an index is allowed.
- **Counter states:**
  - SNT = 00, WNT = 01, WT = 10, ST = 11.
  - Prediction = counter MSB.
  - Taken outcome: increment, saturating at ST.
  - Not-taken outcome: decrement, saturating at SNT.
- **Training:** only when `ex_valid` and the branch is conditional.
  - Jumps and "never" do not modify the BHT or the stats.
  - Jumps still raise `ex_mispredict` when `ex_pred_taken` = 0.
- **Stats:**
  - `stat_branches` increments on each training event.
  - `stat_mispredicts` increments on each training event that mispredicted.
  - Both saturate at all-ones; neither wraps.
  - `stat_clear` wins over a simultaneous increment; the result is 0.
- **Reset:**
  - Every BHT entry goes to WNT.
  - Both stats go to 0.
  - Reset overrides any update in the same cycle.
  - During the reset cycle `if_pred_taken` = 0. Combinational outputs follow their inputs.

## Timing
- `if_pred_taken`, `ex_taken`, `ex_mispredict`: zero-cycle combinational paths.
- BHT update is written at the rising edge that ends the EX cycle and is visible to lookups in the following cycle.
- Same-cycle lookup and update of the same index: the lookup returns the pre-update value. There is no bypass.
- Back-to-back updates to one index in consecutive cycles: each update applies to the result of the previous one. No update is lost.
- Stats are registered and reflect training events up to the previous edge.
- Reset mid-operation: reset takes effect at the first rising edge with `rst` = 1. Pending EX updates in that cycle are discarded.

## Structure
- **`branch_pkg`:**
  - `typedef enum logic [2:0] br_cond_e` for the eight encodings.
  - `typedef enum logic [1:0] bht_state_e`: SNT / WNT / WT / ST.
  - Constant `BHT_RESET = WNT`.
- **Sub-module `bht_sat_counter`:** the 2-bit next-state function, purely combinational (state, taken → next). It is instantiated once on the update path.
- **Storage:** the BHT is a flop array `bht_state_e [ENTRIES]`. Synthesis to RAM is not required because of the whole-table reset.
- **Top level:** `branch_predict_unit` holds the resolver, the mispredict compare, the stats, and the array.

## Test plan
1. **Reset:** assert `rst` 1 cycle. Then every index predicts 0 (`if_pc` 0x0, 0x4, …, 0xFC with ENTRIES=64), and both stats read 0.
2. **Train to taken:** 3× `ex_branch`=000, `ex_zero`=1 at `ex_pc`=0x40.
   - Lookup of `if_pc`=0x40 gives 1 after the first update (WNT→WT).
   - Lookup of 0x140 (an alias) also gives 1.
   - The counter saturates at ST: a single not-taken returns the prediction to 1 (ST→WT).
3. **Flag decode:** check each condition code against its flag rule.
   - `ex_branch`=100 with sign=1, overflow=1 gives `ex_taken`=0.
   - `ex_branch`=110 with carry=0 gives `ex_taken`=1.
   - `ex_branch`=010 gives 0 under any flags.
4. **Mispredicts:**
   - Conditional branch, `ex_pred_taken`=0, resolved taken: `ex_mispredict`=1, and stats advance to branches=1, mispredicts=1.
   - Jump with `ex_pred_taken`=0: `ex_mispredict`=1, stats unchanged, BHT unchanged.
5. **Same-cycle collision:** update 0x80 taken while looking up `if_pc`=0x80. `if_pred_taken`=0 in that cycle and 1 in the next.
6. **Stats boundaries:**
   - With STAT_W=4, 17 training events leave `stat_branches`=15.
   - `stat_clear` asserted together with a training event gives 0.
   - Asserting `rst` during a valid update leaves the entry at WNT.

Source files
------------

// File: rtl/branch_pkg.sv
// Shared types for the branch predictor: condition encodings, BHT counter states
// and the conditional-branch classifier.
package branch_pkg;

    typedef enum logic [2:0] {
        BR_EQ    = 3'b000,
        BR_NE    = 3'b001,
        BR_NEVER = 3'b010,
        BR_JUMP  = 3'b011,
        BR_LT    = 3'b100,
        BR_GE    = 3'b101,
        BR_LTU   = 3'b110,
        BR_GEU   = 3'b111
    } br_cond_e;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } bht_state_e;

    localparam bht_state_e BHT_RESET = WNT;

    // Only real compares train the table; jump/never carry no history.
    function automatic logic is_cond(input br_cond_e c);
        return (c != BR_JUMP) && (c != BR_NEVER);
    endfunction

endpackage

// File: rtl/bht_sat_counter.sv
// 2-bit saturating counter next-state function for one BHT entry.
module bht_sat_counter
    import branch_pkg::*;
(
    input  bht_state_e state,
    input  logic       taken,
    output bht_state_e next
);

    always_comb begin
        next = state;
        unique case (state)
            SNT: next = taken ? WNT : SNT;
            WNT: next = taken ? WT  : SNT;
            WT:  next = taken ? ST  : WNT;
            ST:  next = taken ? ST  : WT;
            default: next = BHT_RESET;
        endcase
    end

endmodule

// File: rtl/branch_predict_unit.sv
// Branch resolver, PC-indexed 2-bit BHT predictor and saturating mispredict stats.
module branch_predict_unit
    import branch_pkg::*;
#(
    parameter int ENTRIES = 64,
    parameter int XLEN    = 32,
    parameter int STAT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [XLEN-1:0]   if_pc,
    output logic              if_pred_taken,
    input  logic              ex_valid,
    input  logic [2:0]        ex_branch,
    input  logic              ex_zero,
    input  logic              ex_carry,
    input  logic              ex_sign,
    input  logic              ex_overflow,
    input  logic [XLEN-1:0]   ex_pc,
    input  logic              ex_pred_taken,
    output logic              ex_taken,
    output logic              ex_mispredict,
    input  logic              stat_clear,
    output logic [STAT_W-1:0] stat_branches,
    output logic [STAT_W-1:0] stat_mispredicts
);

    localparam int IDX_W = $clog2(ENTRIES);

    br_cond_e          cond;
    logic              train;
    logic [IDX_W-1:0]  if_idx;
    logic [IDX_W-1:0]  ex_idx;
    bht_state_e        bht [ENTRIES];
    bht_state_e        bht_next;
    logic              unused_pc_bits;

    assign cond   = br_cond_e'(ex_branch);
    assign if_idx = if_pc[IDX_W+1:2];
    assign ex_idx = ex_pc[IDX_W+1:2];
    assign unused_pc_bits = ^{if_pc[XLEN-1:IDX_W+2], if_pc[1:0],
                              ex_pc[XLEN-1:IDX_W+2], ex_pc[1:0]};

    always_comb begin
        ex_taken = 1'b0;
        unique case (cond)
            BR_EQ:    ex_taken = ex_zero;
            BR_NE:    ex_taken = ~ex_zero;
            BR_LT:    ex_taken = ex_sign ^ ex_overflow;
            BR_GE:    ex_taken = ~(ex_sign ^ ex_overflow);
            BR_LTU:   ex_taken = ~ex_carry;
            BR_GEU:   ex_taken = ex_carry;
            BR_JUMP:  ex_taken = 1'b1;
            BR_NEVER: ex_taken = 1'b0;
            default:  ex_taken = 1'b0;
        endcase
    end

    assign ex_mispredict = ex_valid & (ex_taken != ex_pred_taken);
    assign train         = ex_valid & is_cond(cond);

    // Gated so fetch never sees a stale entry while the table is being reset.
    assign if_pred_taken = ~rst & bht[if_idx][1];

    bht_sat_counter u_ctr (
        .state (bht[ex_idx]),
        .taken (ex_taken),
        .next  (bht_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) bht[i] <= BHT_RESET;
        end else if (train) begin
            bht[ex_idx] <= bht_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || stat_clear) begin
            stat_branches    <= '0;
            stat_mispredicts <= '0;
        end else if (train) begin
            if (~&stat_branches)                     stat_branches    <= stat_branches + 1'b1;
            if (ex_mispredict && ~&stat_mispredicts) stat_mispredicts <= stat_mispredicts + 1'b1;
        end
    end

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed bench for branch_predict_unit (ENTRIES=64, XLEN=32, STAT_W=4).
module tb_branch_predict_unit;

    localparam int ENTRIES = 64;
    localparam int XLEN    = 32;
    localparam int STAT_W  = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [XLEN-1:0]   if_pc;
    logic              if_pred_taken;
    logic              ex_valid;
    logic [2:0]        ex_branch;
    logic              ex_zero, ex_carry, ex_sign, ex_overflow;
    logic [XLEN-1:0]   ex_pc;
    logic              ex_pred_taken;
    logic              ex_taken;
    logic              ex_mispredict;
    logic              stat_clear;
    logic [STAT_W-1:0] stat_branches;
    logic [STAT_W-1:0] stat_mispredicts;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    branch_predict_unit #(.ENTRIES(ENTRIES), .XLEN(XLEN), .STAT_W(STAT_W)) dut (
        .clk              (clk),
        .rst              (rst),
        .if_pc            (if_pc),
        .if_pred_taken    (if_pred_taken),
        .ex_valid         (ex_valid),
        .ex_branch        (ex_branch),
        .ex_zero          (ex_zero),
        .ex_carry         (ex_carry),
        .ex_sign          (ex_sign),
        .ex_overflow      (ex_overflow),
        .ex_pc            (ex_pc),
        .ex_pred_taken    (ex_pred_taken),
        .ex_taken         (ex_taken),
        .ex_mispredict    (ex_mispredict),
        .stat_clear       (stat_clear),
        .stat_branches    (stat_branches),
        .stat_mispredicts (stat_mispredicts)
    );

    typedef struct {
        logic [2:0] br;
        logic       z, c, s, o;
        logic       exp;
    } vec_t;

    task automatic idle();
        ex_valid      = 1'b0;
        ex_branch     = 3'b010;
        ex_zero       = 1'b0;
        ex_carry      = 1'b0;
        ex_sign       = 1'b0;
        ex_overflow   = 1'b0;
        ex_pc         = '0;
        ex_pred_taken = 1'b0;
        stat_clear    = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_br(input logic [2:0] br, input logic [XLEN-1:0] pc,
                            input logic z, input logic pred);
        ex_valid      = 1'b1;
        ex_branch     = br;
        ex_zero       = z;
        ex_pc         = pc;
        ex_pred_taken = pred;
    endtask

    task automatic check_pred(input logic [XLEN-1:0] pc, input logic exp, input string name);
        if_pc = pc;
        #1;
        tests++;
        if (if_pred_taken !== exp) begin
            fails++;
            $display("FAIL %s pc=%h got=%b exp=%b", name, pc, if_pred_taken, exp);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        drive_br(3'b000, 32'h40, 1'b1, 1'b0);
        if_pc = 32'h40;
        #1;
        tests++;
        if (if_pred_taken !== 1'b0) begin
            fails++;
            $display("FAIL reset_cycle_pred got=%b exp=0", if_pred_taken);
        end
        tick();
        rst = 1'b0;
        idle();
        for (int i = 0; i < ENTRIES; i++) check_pred(32'(i * 4), 1'b0, "reset_pred");
        tests++;
        if (stat_branches !== 4'd0 || stat_mispredicts !== 4'd0) begin
            fails++;
            $display("FAIL reset_stats got=%0d/%0d exp=0/0", stat_branches, stat_mispredicts);
        end
    endtask

    task automatic test_train_taken();
        drive_br(3'b000, 32'h40, 1'b1, 1'b0);
        #1;
        tests++;
        if (ex_taken !== 1'b1 || ex_mispredict !== 1'b1) begin
            fails++;
            $display("FAIL train_comb taken=%b misp=%b exp=1/1", ex_taken, ex_mispredict);
        end
        tick();
        check_pred(32'h40, 1'b1, "train_first");
        tick();
        tick();
        idle();
        check_pred(32'h40, 1'b1, "train_st");
        check_pred(32'h140, 1'b1, "train_alias");
        drive_br(3'b000, 32'h40, 1'b0, 1'b1);
        tick();
        idle();
        check_pred(32'h40, 1'b1, "st_to_wt");
        drive_br(3'b000, 32'h40, 1'b0, 1'b1);
        tick();
        idle();
        check_pred(32'h40, 1'b0, "wt_to_wnt");
        // 3 taken with pred 0 mispredict; 2 not-taken with pred 1 also mispredict.
        tests++;
        if (stat_branches !== 4'd5 || stat_mispredicts !== 4'd5) begin
            fails++;
            $display("FAIL train_stats got=%0d/%0d exp=5/5", stat_branches, stat_mispredicts);
        end
        stat_clear = 1'b1;
        tick();
        idle();
        tests++;
        if (stat_branches !== 4'd0 || stat_mispredicts !== 4'd0) begin
            fails++;
            $display("FAIL stat_clear got=%0d/%0d exp=0/0", stat_branches, stat_mispredicts);
        end
    endtask

    task automatic test_flag_decode();
        vec_t v [13];
        v[0]  = '{3'b000, 1, 0, 0, 0, 1};
        v[1]  = '{3'b000, 0, 1, 1, 1, 0};
        v[2]  = '{3'b001, 0, 0, 0, 0, 1};
        v[3]  = '{3'b100, 0, 0, 1, 1, 0};
        v[4]  = '{3'b100, 0, 0, 1, 0, 1};
        v[5]  = '{3'b101, 0, 0, 1, 0, 0};
        v[6]  = '{3'b101, 0, 0, 0, 0, 1};
        v[7]  = '{3'b110, 0, 0, 0, 0, 1};
        v[8]  = '{3'b110, 0, 1, 0, 0, 0};
        v[9]  = '{3'b111, 0, 1, 0, 0, 1};
        v[10] = '{3'b011, 0, 0, 0, 0, 1};
        v[11] = '{3'b010, 1, 1, 1, 1, 0};
        v[12] = '{3'b010, 0, 0, 0, 0, 0};
        idle();
        for (int i = 0; i < 13; i++) begin
            ex_branch   = v[i].br;
            ex_zero     = v[i].z;
            ex_carry    = v[i].c;
            ex_sign     = v[i].s;
            ex_overflow = v[i].o;
            ex_pred_taken = ~v[i].exp;
            #1;
            tests++;
            if (ex_taken !== v[i].exp || ex_mispredict !== 1'b0) begin
                fails++;
                $display("FAIL decode[%0d] br=%b taken=%b exp=%b misp=%b exp=0",
                         i, v[i].br, ex_taken, v[i].exp, ex_mispredict);
            end
        end
        idle();
    endtask

    task automatic test_mispredict();
        drive_br(3'b001, 32'h200, 1'b0, 1'b0);
        #1;
        tests++;
        if (ex_mispredict !== 1'b1) begin
            fails++;
            $display("FAIL misp_cond got=%b exp=1", ex_mispredict);
        end
        tick();
        drive_br(3'b011, 32'h0C, 1'b0, 1'b0);
        #1;
        tests++;
        if (ex_mispredict !== 1'b1 || stat_branches !== 4'd1 || stat_mispredicts !== 4'd1) begin
            fails++;
            $display("FAIL misp_jump misp=%b stats=%0d/%0d exp=1 1/1",
                     ex_mispredict, stat_branches, stat_mispredicts);
        end
        tick();
        ex_pred_taken = 1'b1;
        #1;
        tests++;
        if (ex_mispredict !== 1'b0 || stat_branches !== 4'd1 || stat_mispredicts !== 4'd1) begin
            fails++;
            $display("FAIL jump_stats misp=%b stats=%0d/%0d exp=0 1/1",
                     ex_mispredict, stat_branches, stat_mispredicts);
        end
        ex_branch = 3'b010;
        #1;
        tests++;
        if (ex_mispredict !== 1'b1) begin
            fails++;
            $display("FAIL misp_never got=%b exp=1", ex_mispredict);
        end
        tick();
        idle();
        check_pred(32'h0C, 1'b0, "jump_no_train");
        check_pred(32'h200, 1'b1, "cond_trained");
        tests++;
        if (stat_branches !== 4'd1 || stat_mispredicts !== 4'd1) begin
            fails++;
            $display("FAIL never_stats got=%0d/%0d exp=1/1", stat_branches, stat_mispredicts);
        end
    endtask

    task automatic test_collision();
        drive_br(3'b000, 32'h80, 1'b1, 1'b0);
        check_pred(32'h80, 1'b0, "collide_same");
        tick();
        idle();
        check_pred(32'h80, 1'b1, "collide_next");
    endtask

    task automatic test_stats_bounds();
        stat_clear = 1'b1;
        tick();
        idle();
        for (int i = 0; i < 17; i++) begin
            drive_br(3'b000, 32'h10, 1'b1, 1'b0);
            tick();
        end
        idle();
        tests++;
        if (stat_branches !== 4'd15 || stat_mispredicts !== 4'd15) begin
            fails++;
            $display("FAIL stat_sat got=%0d/%0d exp=15/15", stat_branches, stat_mispredicts);
        end
        drive_br(3'b000, 32'h10, 1'b1, 1'b0);
        stat_clear = 1'b1;
        tick();
        idle();
        tests++;
        if (stat_branches !== 4'd0 || stat_mispredicts !== 4'd0) begin
            fails++;
            $display("FAIL clear_wins got=%0d/%0d exp=0/0", stat_branches, stat_mispredicts);
        end
        drive_br(3'b000, 32'h20, 1'b1, 1'b0);
        tick();
        check_pred(32'h20, 1'b1, "pre_rst_wt");
        rst = 1'b1;
        check_pred(32'h20, 1'b0, "rst_cycle_gate");
        tick();
        rst = 1'b0;
        idle();
        check_pred(32'h20, 1'b0, "rst_discards");
        check_pred(32'h10, 1'b0, "rst_other_entry");
    endtask

    initial begin
        rst = 1'b1;
        if_pc = '0;
        idle();
        test_reset();
        test_train_taken();
        test_flag_decode();
        test_mispredict();
        test_collision();
        test_stats_bounds();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
